// File: rtl/instr_byte_loader.sv
// rtl/instr_byte_loader.sv - frames a byte-serial program stream and writes 32-bit words into instruction memory
module instr_byte_loader #(
    parameter int          DEPTH      = 64,
    parameter int          ADDR_W     = 6,
    parameter logic [7:0]  START_BYTE = 8'hFE,
    parameter logic [7:0]  END_BYTE   = 8'hFF
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic [7:0]        instr_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [1:0]      state;
    logic [1:0]      idx;
    logic [ADDR_W:0] word_cnt;
    logic [23:0]     byte_buf;

    assign word_cnt_o = word_cnt;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            word_cnt <= '0;
            byte_buf <= 24'd0;
            we_o     <= 1'b0;
            waddr_o  <= '0;
            wdata_o  <= 32'd0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            we_o <= 1'b0;
            if (valid_i) begin
                case (state)
                    ST_IDLE: begin
                        if (instr_i == START_BYTE) begin
                            state    <= ST_LOAD;
                            idx      <= 2'd0;
                            word_cnt <= '0;
                        end
                    end
                    ST_LOAD: begin
                        // Markers only count at a word boundary; inside a word every byte is data.
                        if (idx == 2'd0) begin
                            if (instr_i == END_BYTE) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end else if (instr_i == START_BYTE) begin
                                word_cnt <= '0;
                            end else if (word_cnt == DEPTH_C) begin
                                state <= ST_ERR;
                                err_o <= 1'b1;
                            end else begin
                                byte_buf[7:0] <= instr_i;
                                idx           <= 2'd1;
                            end
                        end else if (idx == 2'd3) begin
                            we_o     <= 1'b1;
                            waddr_o  <= word_cnt[ADDR_W-1:0];
                            wdata_o  <= {instr_i, byte_buf};
                            word_cnt <= word_cnt + CNT_ONE;
                            idx      <= 2'd0;
                        end else begin
                            if (idx == 2'd1) byte_buf[15:8]  <= instr_i;
                            else             byte_buf[23:16] <= instr_i;
                            idx <= idx + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/instr_byte_loader.md
Name: instr_byte_loader

Overview:
- Sits between the external byte-serial program port (instr_i) and the CPU instruction memory write port.
- Frames the byte stream with start/end marker bytes and packs each 4 data bytes into one 32-bit little-endian instruction word.
- Writes each word to consecutive instruction-memory word addresses.
- Asserts a sticky done flag that releases the core once the program is loaded.

Parameters:
- DEPTH, 64, instruction memory depth in 32-bit words.
- ADDR_W, 6, word-address width; must satisfy 2**ADDR_W >= DEPTH.
- START_BYTE, 8'hFE, start-of-program marker.
- END_BYTE, 8'hFF, end-of-program marker.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- valid_i  input  1  instr_i carries a byte this cycle.
- instr_i  input  8  program byte stream.
- we_o  output  1  instruction memory write strobe, one cycle per word.
- waddr_o  output  ADDR_W  word address for the write.
- wdata_o  output  32  assembled instruction word.
- word_cnt_o  output  ADDR_W+1  number of words written so far.
- done_o  output  1  program loaded; sticky until reset.
- err_o  output  1  overflow error; sticky until reset.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, byte index=0, word_cnt=0.
  - we_o=0, waddr_o=0, wdata_o=0, done_o=0, err_o=0.
  - Reset asserted mid-load discards the partial word; no we_o pulse occurs.
- Bytes are consumed only in cycles with valid_i=1. valid_i=0 cycles hold all state.
- IDLE:
  - Byte == START_BYTE -> LOAD, with byte index=0 and word_cnt=0.
  - Any other byte is ignored.
- LOAD, byte index 0 (word boundary):
  - END_BYTE -> DONE.
  - START_BYTE -> restart: word_cnt=0, stay in LOAD, nothing written.
  - Other byte with word_cnt==DEPTH -> ERR.
  - Otherwise the byte is stored as bits [7:0] and index becomes 1.
- Markers are recognised only at index 0. RV32I low bytes 0xFE and 0xFF are non-32-bit opcodes, so they never start a valid word.
- LOAD, index 1..3:
  - The byte is always data and goes to bits [8*idx+7 : 8*idx], including 0xFE and 0xFF.
  - Index advances modulo 4.
- Word completion:
  - The cycle after the 4th byte is sampled: we_o=1 for exactly one cycle, waddr_o=word_cnt (pre-increment), wdata_o=assembled word.
  - word_cnt increments on the same edge that raises we_o.
  - Latency from 4th byte sample to we_o is 1 cycle. Back-to-back words give we_o every 4 valid cycles.
- DONE:
  - done_o=1 from the edge that samples END_BYTE onward.
  - All further bytes are ignored, including START_BYTE. Only reset re-arms the block.
  - we_o stays 0.
- ERR:
  - err_o=1, we_o=0, done_o=0, all input ignored until reset.
  - word_cnt_o holds DEPTH.
- Outside a write cycle, waddr_o and wdata_o hold the values of the last write. we_o=0 in all states except the write cycle.
- Exactly DEPTH words followed by END_BYTE is legal and reaches DONE.
- END_BYTE directly after START_BYTE gives DONE with word_cnt_o=0.

Test Plan:
- Reset, then stream 00,00,FE, 13,05,10,00, 93,05,20,00, FF with valid_i=1. Required response:
  - we_o pulses twice, 4 cycles apart.
  - First write: waddr 0, wdata 32'h00100513. Second write: waddr 1, wdata 32'h00200593.
  - done_o rises the cycle after FF is sampled; word_cnt_o=2.
- Marker bytes inside a word: FE, 33, FF, FE, FF, FF. Required: one write with wdata 32'hFFFEFF33 at waddr 0, then done_o=1.
- Overflow: FE, then 65 full words, then FF. Required:
  - 64 writes to waddr 0..63.
  - err_o=1 after the first byte of word 65; no 65th write; done_o stays 0.
- Reset mid-word: FE, 13, 05, then reset_n low for 1 cycle, then 10, 00. Required:
  - No we_o at any point; state IDLE.
  - A subsequent FE, 4 data bytes gives a write at waddr 0.
- Gaps and restart: FE, then 4 data bytes interleaved with valid_i=0 cycles, then FE at a word boundary, then 4 bytes, then FF. Required:
  - First word written at waddr 0.
  - The restart makes the second word also write at waddr 0.
  - Final word_cnt_o=1, done_o=1.
- After DONE: send FE, 11, 22, 33, 44. Required: no we_o, done_o stays 1, word_cnt_o unchanged.
